// File: rtl/draw_scheduler_pkg.sv
// Shared types and constants for the draw scheduler: default pixel field widths,
// the scheduler state encoding and the index-width helper.
package draw_pkg;

    localparam int DRAW_X_W = 8;
    localparam int DRAW_Y_W = 7;
    localparam int DRAW_C_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE
    } sched_state_e;

    // Smallest width w >= 1 with 2**w >= n; used for client indices and the watchdog.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        for (int k = 1; k < 32; k++) begin
            if ((1 << w) < n) w = k + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Client-side start/done/pixel bus plus the single VGA adapter write port.
// The scheduler is the master; clients and the adapter sit on the slave side.
interface draw_scheduler_if import draw_pkg::*; #(
    parameter int NUM_CLIENTS = 8,
    parameter int X_W         = DRAW_X_W,
    parameter int Y_W         = DRAW_Y_W,
    parameter int C_W         = DRAW_C_W
);
    logic [NUM_CLIENTS-1:0]     start_out;
    logic [NUM_CLIENTS-1:0]     done_in;
    logic [NUM_CLIENTS-1:0]     plot_in;
    logic [NUM_CLIENTS*X_W-1:0] x_in;
    logic [NUM_CLIENTS*Y_W-1:0] y_in;
    logic [NUM_CLIENTS*C_W-1:0] colour_in;

    logic [X_W-1:0]             x_out;
    logic [Y_W-1:0]             y_out;
    logic [C_W-1:0]             colour_out;
    logic                       plot_out;

    modport master (
        output start_out, x_out, y_out, colour_out, plot_out,
        input  done_in, plot_in, x_in, y_in, colour_in
    );

    modport slave (
        input  start_out, x_out, y_out, colour_out, plot_out,
        output done_in, plot_in, x_in, y_in, colour_in
    );
endinterface

// File: rtl/draw_scheduler_pick.sv
// Finds the lowest enabled client index, either from zero or strictly above
// the current index.
module draw_sched_pick import draw_pkg::*; #(
    parameter int NUM_CLIENTS = 8,
    parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] mask_i,
    input  logic [IDX_W-1:0]       idx_i,
    input  logic                   from_start_i,
    output logic [IDX_W-1:0]       next_idx_o,
    output logic                   found_o
);

    // Scanning downwards lets the lowest qualifying index win the last assignment.
    always_comb begin
        next_idx_o = '0;
        found_o    = 1'b0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(idx_i)))) begin
                next_idx_o = IDX_W'(i);
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin-by-index draw scheduler: grants one client at a time with a
// start/done handshake and forwards the granted client's pixels to the VGA port.
module draw_scheduler import draw_pkg::*; #(
    parameter int NUM_CLIENTS = 8,
    parameter int X_W         = DRAW_X_W,
    parameter int Y_W         = DRAW_Y_W,
    parameter int C_W         = DRAW_C_W,
    parameter int TIMEOUT     = 32768,
    parameter int FRAME_SYNC  = 1,
    localparam int IDX_W      = idx_width(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   frame_tick,
    input  logic [NUM_CLIENTS-1:0] enable_mask,
    draw_scheduler_if.master       bus,
    output logic                   busy,
    output logic [IDX_W-1:0]       active_idx,
    output logic                   round_done,
    output logic [15:0]            round_count,
    output logic [NUM_CLIENTS-1:0] timeout_err
);

    localparam int              WD_W   = idx_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    sched_state_e           state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [WD_W-1:0]        wd_q;
    logic [NUM_CLIENTS-1:0] start_q;
    logic [X_W-1:0]         x_q;
    logic [Y_W-1:0]         y_q;
    logic [C_W-1:0]         colour_q;
    logic                   plot_q;
    logic                   round_done_q;
    logic [15:0]            round_count_q;
    logic [NUM_CLIENTS-1:0] err_q;

    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_colour;
    logic             sel_plot;
    logic             sel_done;
    logic [IDX_W-1:0] next_idx;
    logic             next_found;
    logic [IDX_W-1:0] first_idx;
    logic             first_found;

    draw_sched_pick #(.NUM_CLIENTS(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick_next (
        .mask_i       (enable_mask),
        .idx_i        (idx_q),
        .from_start_i (1'b0),
        .next_idx_o   (next_idx),
        .found_o      (next_found)
    );

    draw_sched_pick #(.NUM_CLIENTS(NUM_CLIENTS), .IDX_W(IDX_W)) u_pick_first (
        .mask_i       (enable_mask),
        .idx_i        ('0),
        .from_start_i (1'b1),
        .next_idx_o   (first_idx),
        .found_o      (first_found)
    );

    // Only the granted client's fields reach the FSM; everyone else is invisible.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_plot   = 1'b0;
        sel_done   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_x      = bus.x_in[i*X_W +: X_W];
                sel_y      = bus.y_in[i*Y_W +: Y_W];
                sel_colour = bus.colour_in[i*C_W +: C_W];
                sel_plot   = bus.plot_in[i];
                sel_done   = bus.done_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            wd_q          <= '0;
            start_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            round_done_q  <= 1'b0;
            round_count_q <= '0;
            err_q         <= '0;
        end else begin
            start_q      <= '0;
            round_done_q <= 1'b0;
            plot_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run && first_found) begin
                        if (FRAME_SYNC != 0) begin
                            state_q <= ST_HOLD;
                        end else begin
                            idx_q   <= first_idx;
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!run) begin
                        state_q <= ST_IDLE;
                    end else if (frame_tick && first_found) begin
                        idx_q   <= first_idx;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_q <= NUM_CLIENTS'(1) << idx_q;
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    x_q      <= sel_x;
                    y_q      <= sel_y;
                    colour_q <= sel_colour;
                    plot_q   <= sel_plot;
                    // A completion in the final watchdog cycle still counts as success.
                    if (sel_done) begin
                        state_q <= ST_ADVANCE;
                    end else if (wd_q == WD_MAX) begin
                        err_q[idx_q] <= 1'b1;
                        state_q      <= ST_ADVANCE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (next_found) begin
                        if (run) begin
                            idx_q   <= next_idx;
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        round_done_q  <= 1'b1;
                        round_count_q <= round_count_q + 16'd1;
                        if (run && first_found) begin
                            if (FRAME_SYNC != 0) begin
                                state_q <= ST_HOLD;
                            end else begin
                                idx_q   <= first_idx;
                                state_q <= ST_ISSUE;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.start_out  = start_q;
    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = colour_q;
    assign bus.plot_out   = plot_q;

    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_ADVANCE);
    assign active_idx  = idx_q;
    assign round_done  = round_done_q;
    assign round_count = round_count_q;
    assign timeout_err = err_q;

endmodule
